wt_mem_arbiter: RTL and testbench

Parametrised N-requester memory arbiter between the L1 caches (and any additional bus masters) and the single memory adapter port. It replaces the fixed icache/dcache two-way plumbing with a configurable number of requester ports, round-robin or fixed-priority arbitration, and per-port outstanding-transaction credits. It also routes each return beat back to its originating port using a port index appended to the transaction ID.

---
 rtl/wt_cache_pkg.sv | 21 ++
 rtl/wt_arb_pick.sv | 34 +++
 rtl/wt_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_wt_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
// Shared cache-subsystem types: arbitration mode and helpers that pack and
// unpack the {port index, local tid} memory transaction ID.
package wt_cache_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    function automatic logic [31:0] pack_tid(input logic [31:0] idx,
                                             input logic [31:0] tid,
                                             input int          tid_w);
        return (idx << tid_w) | tid;
    endfunction

    function automatic logic [31:0] unpack_idx(input logic [31:0] full,
                                               input int          tid_w);
        return full >> tid_w;
    endfunction

endpackage

// File: rtl/wt_arb_pick.sv
// Combinational N-way picker: round-robin from a start pointer, or fixed
// priority with the lowest index winning.
module wt_arb_pick
    import wt_cache_pkg::*;
#(
    parameter int N    = 3,
    parameter int IdxW = 2
) (
    input  logic [N-1:0]    elig,
    input  logic [IdxW-1:0] start,
    input  arb_mode_e       mode,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] gnt_idx
);

    int   pos;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < N; k++) begin
            pos = (mode == ARB_FIXED) ? k : (int'(start) + k) % N;
            if (!found && elig[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                gnt_idx  = IdxW'(pos);
            end
        end
    end

endmodule

// File: rtl/wt_mem_arbiter.sv
// N-port memory arbiter: one-entry output register, per-port credit
// counters and zero-latency return routing by the port index in the ID.
module wt_mem_arbiter
    import wt_cache_pkg::*;
#(
    parameter int NumPorts       = 3,
    parameter int ReqWidth       = 128,
    parameter int RtrnWidth      = 160,
    parameter int TidWidth       = 2,
    parameter int MaxOutstanding = 4,
    parameter int PrioMode       = 0,
    parameter int PortIdxW       = $clog2(NumPorts)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumPorts-1:0]            port_req_i,
    output logic [NumPorts-1:0]            port_ack_o,
    input  logic [NumPorts*ReqWidth-1:0]   port_data_i,
    input  logic [NumPorts*TidWidth-1:0]   port_tid_i,
    output logic [NumPorts-1:0]            port_rtrn_vld_o,
    output logic [RtrnWidth-1:0]           port_rtrn_o,
    output logic [TidWidth-1:0]            port_rtrn_tid_o,
    output logic                           mem_req_o,
    input  logic                           mem_ack_i,
    output logic [ReqWidth-1:0]            mem_data_o,
    output logic [PortIdxW+TidWidth-1:0]   mem_tid_o,
    input  logic                           mem_rtrn_vld_i,
    input  logic [RtrnWidth-1:0]           mem_rtrn_i,
    input  logic [PortIdxW+TidWidth-1:0]   mem_rtrn_tid_i,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int CntW    = $clog2(MaxOutstanding + 1);
    localparam int MemTidW = PortIdxW + TidWidth;

    logic [ReqWidth-1:0] data_arr [NumPorts];
    logic [TidWidth-1:0] tid_arr  [NumPorts];
    logic [CntW-1:0]     cnt      [NumPorts];
    logic [CntW-1:0]     cnt_nxt  [NumPorts];

    logic                reg_vld;
    logic [ReqWidth-1:0] reg_data;
    logic [MemTidW-1:0]  reg_tid;
    logic [PortIdxW-1:0] last_grant, rr_start, gnt_idx, rtrn_idx;
    logic [NumPorts-1:0] elig, gnt;
    logic                reg_free, grant, idx_ok;
    logic [MemTidW-1:0]  gnt_tid;
    logic [31-MemTidW:0] unused_tid_hi;
    logic [31-PortIdxW:0] unused_idx_hi;
    arb_mode_e           mode;

    for (genvar g = 0; g < NumPorts; g++) begin : g_split
        assign data_arr[g] = port_data_i[g*ReqWidth +: ReqWidth];
        assign tid_arr[g]  = port_tid_i[g*TidWidth +: TidWidth];
    end

    assign mode     = (PrioMode != 0) ? ARB_FIXED : ARB_RR;
    assign rr_start = (last_grant == PortIdxW'(NumPorts - 1)) ? '0 : last_grant + 1'b1;

    always_comb begin
        elig = '0;
        for (int p = 0; p < NumPorts; p++)
            elig[p] = port_req_i[p] && (cnt[p] < CntW'(MaxOutstanding));
    end

    wt_arb_pick #(.N(NumPorts), .IdxW(PortIdxW)) u_pick (
        .elig    (elig),
        .start   (rr_start),
        .mode    (mode),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The register accepts a new entry in the same cycle it is drained.
    assign reg_free   = !reg_vld || mem_ack_i;
    assign grant      = reg_free && (|elig);
    assign port_ack_o = grant ? gnt : '0;

    assign {unused_tid_hi, gnt_tid} = pack_tid(32'(gnt_idx), 32'(tid_arr[gnt_idx]), TidWidth);
    assign {unused_idx_hi, rtrn_idx} = unpack_idx(32'(mem_rtrn_tid_i), TidWidth);
    assign idx_ok = 32'(rtrn_idx) < 32'(NumPorts);

    always_comb begin
        port_rtrn_vld_o = '0;
        err_o           = 1'b0;
        if (mem_rtrn_vld_i) begin
            if (!idx_ok) begin
                err_o = 1'b1;
            end else begin
                port_rtrn_vld_o[rtrn_idx] = 1'b1;
                err_o = (cnt[rtrn_idx] == '0);
            end
        end
    end

    assign port_rtrn_o     = mem_rtrn_i;
    assign port_rtrn_tid_o = mem_rtrn_tid_i[TidWidth-1:0];
    assign mem_req_o       = reg_vld;
    assign mem_data_o      = reg_data;
    assign mem_tid_o       = reg_tid;

    // A return to a port whose count is already zero does not decrement.
    always_comb begin
        busy_o = reg_vld;
        for (int p = 0; p < NumPorts; p++) begin
            cnt_nxt[p] = cnt[p];
            if (port_ack_o[p] && !(port_rtrn_vld_o[p] && cnt[p] != '0))
                cnt_nxt[p] = cnt[p] + 1'b1;
            else if (!port_ack_o[p] && port_rtrn_vld_o[p] && cnt[p] != '0)
                cnt_nxt[p] = cnt[p] - 1'b1;
            if (cnt[p] != '0)
                busy_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_vld    <= 1'b0;
            reg_data   <= '0;
            reg_tid    <= '0;
            last_grant <= PortIdxW'(NumPorts - 1);
            for (int p = 0; p < NumPorts; p++)
                cnt[p] <= '0;
        end else begin
            if (grant) begin
                reg_vld    <= 1'b1;
                reg_data   <= data_arr[gnt_idx];
                reg_tid    <= gnt_tid;
                last_grant <= gnt_idx;
            end else if (mem_ack_i) begin
                reg_vld <= 1'b0;
            end
            for (int p = 0; p < NumPorts; p++)
                cnt[p] <= cnt_nxt[p];
        end
    end

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Scoreboard bench for wt_mem_arbiter: one round-robin and one fixed-priority
// instance, directed stimulus with expected transactions queued at issue time.
module tb_wt_mem_arbiter;

    localparam int RW = 128;
    localparam int TW = 160;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [2:0]    req, fx_req, ack, fx_ack, rvld, fx_rvld;
    logic [RW-1:0] pd [3];
    logic [RW-1:0] npd [3];
    logic [1:0]    pt [3];
    logic [1:0]    npt [3];
    logic [3*RW-1:0] pdata_flat;
    logic [5:0]    ptid_flat;
    logic          mem_req, mem_ack, fx_mem_req, fx_mem_ack;
    logic [RW-1:0] mem_data, fx_mem_data;
    logic [3:0]    mem_tid, fx_mem_tid;
    logic          rtrn_vld;
    logic [TW-1:0] rtrn, rtrn_o, fx_rtrn_o;
    logic [3:0]    rtrn_tid;
    logic [1:0]    rtrn_tid_o, fx_rtrn_tid_o;
    logic          busy, err, fx_busy, fx_err;

    logic          pend_rv;
    logic [3:0]    pend_tid;
    logic [TW-1:0] pend_data;
    logic          no_push;
    int            ser;

    assign pdata_flat = {pd[2], pd[1], pd[0]};
    assign ptid_flat  = {pt[2], pt[1], pt[0]};

    wt_mem_arbiter #(.PrioMode(0)) u_rr (
        .clk_i(clk), .rst_i(rst),
        .port_req_i(req), .port_ack_o(ack),
        .port_data_i(pdata_flat), .port_tid_i(ptid_flat),
        .port_rtrn_vld_o(rvld), .port_rtrn_o(rtrn_o), .port_rtrn_tid_o(rtrn_tid_o),
        .mem_req_o(mem_req), .mem_ack_i(mem_ack), .mem_data_o(mem_data), .mem_tid_o(mem_tid),
        .mem_rtrn_vld_i(rtrn_vld), .mem_rtrn_i(rtrn), .mem_rtrn_tid_i(rtrn_tid),
        .busy_o(busy), .err_o(err)
    );

    wt_mem_arbiter #(.PrioMode(1)) u_fx (
        .clk_i(clk), .rst_i(rst),
        .port_req_i(fx_req), .port_ack_o(fx_ack),
        .port_data_i(pdata_flat), .port_tid_i(ptid_flat),
        .port_rtrn_vld_o(fx_rvld), .port_rtrn_o(fx_rtrn_o), .port_rtrn_tid_o(fx_rtrn_tid_o),
        .mem_req_o(fx_mem_req), .mem_ack_i(fx_mem_ack), .mem_data_o(fx_mem_data), .mem_tid_o(fx_mem_tid),
        .mem_rtrn_vld_i(1'b0), .mem_rtrn_i('0), .mem_rtrn_tid_i(4'h0),
        .busy_o(fx_busy), .err_o(fx_err)
    );

    typedef struct packed {
        logic [3:0]    tid;
        logic [RW-1:0] data;
    } dn_t;

    typedef struct packed {
        logic [2:0]    vld;
        logic          err;
        logic [1:0]    tid;
        logic [TW-1:0] data;
    } rt_t;

    dn_t q_dn [$];
    dn_t q_fx [$];
    rt_t q_rt [$];
    dn_t e_dn, e_fx;
    rt_t e_rt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] pdata(input int p, input int n);
        return {32'hDA7A0000, 56'(0), 8'(p), 24'(0), 8'(n)};
    endfunction

    // Monitors: compare every downstream handshake and every return beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req && mem_ack) begin
                if (q_dn.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dn_unexpected: got tid %0h data %0h expected none", mem_tid, mem_data);
                end else begin
                    e_dn = q_dn.pop_front();
                    chk("dn_tid", 160'(mem_tid), 160'(e_dn.tid));
                    chk("dn_data", 160'(mem_data), 160'(e_dn.data));
                end
            end
            if (fx_mem_req && fx_mem_ack) begin
                if (q_fx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fx_unexpected: got tid %0h expected none", fx_mem_tid);
                end else begin
                    e_fx = q_fx.pop_front();
                    chk("fx_tid", 160'(fx_mem_tid), 160'(e_fx.tid));
                    chk("fx_data", 160'(fx_mem_data), 160'(e_fx.data));
                end
            end
            if (rvld != 3'b000 || err) begin
                if (q_rt.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rt_unexpected: got vld %b err %b expected none", rvld, err);
                end else begin
                    e_rt = q_rt.pop_front();
                    chk("rt_vld", 160'(rvld), 160'(e_rt.vld));
                    chk("rt_err", 160'(err), 160'(e_rt.err));
                    if (e_rt.vld != 3'b000) begin
                        chk("rt_tid", 160'(rtrn_tid_o), 160'(e_rt.tid));
                        chk("rt_data", rtrn_o, e_rt.data);
                    end
                end
            end
        end
    end

    task automatic cyc(input logic [2:0] rq, input logic mack, input logic [2:0] eack, input string nm);
        @(posedge clk); #1;
        pd = npd;
        pt = npt;
        req = rq;
        mem_ack = mack;
        rtrn_vld = pend_rv;
        rtrn_tid = pend_tid;
        rtrn = pend_data;
        pend_rv = 1'b0;
        @(negedge clk);
        chk(nm, 160'(ack), 160'(eack));
        if (!no_push)
            for (int p = 0; p < 3; p++)
                if (eack[p]) q_dn.push_back(dn_t'({2'(p), pt[p], pd[p]}));
    endtask

    task automatic fcyc(input logic [2:0] rq, input logic [2:0] eack, input string nm);
        @(posedge clk); #1;
        pd = npd;
        pt = npt;
        fx_req = rq;
        rtrn_vld = 1'b0;
        @(negedge clk);
        chk(nm, 160'(fx_ack), 160'(eack));
        for (int p = 0; p < 3; p++)
            if (eack[p]) q_fx.push_back(dn_t'({2'(p), pt[p], pd[p]}));
    endtask

    task automatic sched_ret(input logic [3:0] t, input logic [2:0] ev, input logic ee);
        rt_t r;
        ser++;
        pend_rv   = 1'b1;
        pend_tid  = t;
        pend_data = {16'hBEEF, 136'(ser), 4'h0, t};
        r.vld  = ev;
        r.err  = ee;
        r.tid  = t[1:0];
        r.data = pend_data;
        q_rt.push_back(r);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; req = '0; fx_req = '0; mem_ack = 1'b0; fx_mem_ack = 1'b1;
        rtrn_vld = 1'b0; rtrn = '0; rtrn_tid = '0;
        pend_rv = 1'b0; pend_tid = '0; pend_data = '0; no_push = 1'b0; ser = 0;
        for (int p = 0; p < 3; p++) begin
            npd[p] = '0; npt[p] = '0;
        end
        pd = npd; pt = npt;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", 160'(mem_req), 160'(0));
        chk("rst_busy", 160'(busy), 160'(0));
        chk("rst_ack", 160'(ack), 160'(0));
        chk("rst_rvld", 160'(rvld), 160'(0));
        chk("rst_err", 160'(err), 160'(0));
        chk("rst_fx_mem_req", 160'(fx_mem_req), 160'(0));

        // Round-robin with all ports contending
        for (int p = 0; p < 3; p++) begin
            npd[p] = pdata(p, 1); npt[p] = 2'(p);
        end
        for (int i = 0; i < 6; i++)
            cyc(3'b111, 1'b1, 3'(1) << (i % 3), "rr_ack");
        cyc(3'b000, 1'b1, 3'b000, "rr_drain");
        for (int p = 0; p < 3; p++)
            for (int j = 0; j < 2; j++) begin
                sched_ret({2'(p), 2'(p)}, 3'(1) << p, 1'b0);
                cyc(3'b000, 1'b1, 3'b000, "rr_ret_idle");
            end
        cyc(3'b000, 1'b1, 3'b000, "rr_idle");
        chk("rr_busy_clear", 160'(busy), 160'(0));

        // Credit limit on port 1
        npd[1] = pdata(1, 2); npt[1] = 2'd3;
        for (int i = 0; i < 4; i++) cyc(3'b010, 1'b1, 3'b010, "cr_ack");
        cyc(3'b010, 1'b1, 3'b000, "cr_blocked");
        cyc(3'b010, 1'b1, 3'b000, "cr_blocked");
        chk("cr_busy", 160'(busy), 160'(1));
        sched_ret(4'b0111, 3'b010, 1'b0);
        cyc(3'b010, 1'b1, 3'b000, "cr_ret_cycle");
        cyc(3'b010, 1'b1, 3'b010, "cr_after_ret");
        cyc(3'b000, 1'b1, 3'b000, "cr_drop");
        for (int j = 0; j < 4; j++) begin
            sched_ret(4'b0111, 3'b010, 1'b0);
            cyc(3'b000, 1'b1, 3'b000, "cr_ret_idle");
        end
        cyc(3'b000, 1'b1, 3'b000, "cr_idle");
        chk("cr_busy_clear", 160'(busy), 160'(0));

        // Grant and return to port 0 in the same cycle, then a 5-cycle stall
        npd[0] = pdata(0, 3); npt[0] = 2'd1;
        cyc(3'b001, 1'b1, 3'b001, "sim_ack");
        cyc(3'b001, 1'b1, 3'b001, "sim_ack");
        npd[0] = pdata(0, 4);
        sched_ret(4'b0001, 3'b001, 1'b0);
        cyc(3'b001, 1'b1, 3'b001, "sim_ack_and_ret");
        npd[0] = pdata(0, 5);
        for (int i = 0; i < 5; i++) begin
            cyc(3'b001, 1'b0, 3'b000, "stall_no_ack");
            chk("stall_mem_req", 160'(mem_req), 160'(1));
            chk("stall_data", 160'(mem_data), 160'(pdata(0, 4)));
        end
        cyc(3'b001, 1'b1, 3'b001, "post_stall_ack");
        cyc(3'b001, 1'b1, 3'b001, "post_stall_ack");
        cyc(3'b001, 1'b1, 3'b000, "sim_credit_full");
        cyc(3'b000, 1'b1, 3'b000, "sim_drop");
        for (int j = 0; j < 4; j++) begin
            sched_ret(4'b0001, 3'b001, 1'b0);
            cyc(3'b000, 1'b1, 3'b000, "sim_ret_idle");
        end
        cyc(3'b000, 1'b1, 3'b000, "sim_idle");
        chk("sim_busy_clear", 160'(busy), 160'(0));

        // Bad returns
        sched_ret(4'b1110, 3'b000, 1'b1);
        cyc(3'b000, 1'b1, 3'b000, "bad_idx_idle");
        cyc(3'b000, 1'b1, 3'b000, "bad_idle");
        chk("bad_err_pulse", 160'(err), 160'(0));
        sched_ret(4'b1000, 3'b100, 1'b1);
        cyc(3'b000, 1'b1, 3'b000, "bad_zero_idle");
        cyc(3'b000, 1'b1, 3'b000, "bad_idle");
        chk("bad_zero_busy", 160'(busy), 160'(0));
        chk("bad_zero_err_pulse", 160'(err), 160'(0));

        // Reset with a pending request and a non-zero count
        npd[1] = pdata(1, 6); npt[1] = 2'd0;
        no_push = 1'b1;
        cyc(3'b010, 1'b0, 3'b010, "rst_pre_ack");
        no_push = 1'b0;
        cyc(3'b000, 1'b0, 3'b000, "rst_hold");
        chk("rst_pre_mem_req", 160'(mem_req), 160'(1));
        chk("rst_pre_busy", 160'(busy), 160'(1));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_post_mem_req", 160'(mem_req), 160'(0));
        chk("rst_post_busy", 160'(busy), 160'(0));
        for (int p = 0; p < 3; p++) begin
            npd[p] = pdata(p, 8); npt[p] = 2'(p);
        end
        cyc(3'b111, 1'b1, 3'b001, "rst_first_grant");
        cyc(3'b000, 1'b1, 3'b000, "rst_drain");
        sched_ret(4'b0100, 3'b010, 1'b1);
        cyc(3'b000, 1'b1, 3'b000, "rst_stale_ret_idle");
        cyc(3'b000, 1'b1, 3'b000, "rst_idle");

        // Fixed priority: port 0 beats port 2 until it drops
        npd[0] = pdata(0, 7); npd[2] = pdata(2, 7);
        for (int i = 0; i < 3; i++) fcyc(3'b101, 3'b001, "fx_port0_wins");
        fcyc(3'b100, 3'b100, "fx_port2_after_drop");
        fcyc(3'b000, 3'b000, "fx_drain");
        fcyc(3'b000, 3'b000, "fx_idle");

        chk("dn_queue_empty", 160'(q_dn.size()), 160'(0));
        chk("fx_queue_empty", 160'(q_fx.size()), 160'(0));
        chk("rt_queue_empty", 160'(q_rt.size()), 160'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
